bcd_entry_controller: RTL and testbench

Sequential decimal-entry front end for the ALU board: accepts digit, sign and edit keystrokes and assembles a 4-digit signed decimal operand. On ENTER it converts the digits to a 12-bit two's-complement value with one multiply-accumulate per clock. It drives the results into the ALU operand registers. It also exposes the live digit buffer to the seven-segment display path, making it the input-side counterpart of the value-to-BCD display chain.

---
 rtl/bcd_entry_controller.sv | 141 ++++++++++++++
 tb/tb_bcd_entry_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry_controller.sv
// Keypad decimal-entry front end. It assembles a 4-digit signed BCD operand and
// converts it to a saturated 12-bit two's-complement value with one MAC per clock.
module bcd_entry_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        neg,
  output logic [2:0]  digit_count,
  output logic [11:0] val_out,
  output logic        val_valid,
  output logic        val_err
);

  typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

  state_t      state;
  logic [13:0] acc;
  logic [1:0]  step;
  logic [3:0]  mac_digit;
  logic [13:0] mac_next;
  logic [11:0] sat_val;
  logic        sat_err;

  // Step 0 consumes the most significant digit.
  always_comb begin
    mac_digit = digit3;
    case (step)
      2'd0:    mac_digit = digit3;
      2'd1:    mac_digit = digit2;
      2'd2:    mac_digit = digit1;
      default: mac_digit = digit0;
    endcase
  end

  assign mac_next = (acc * 14'd10) + {10'd0, mac_digit};

  // A negative magnitude of exactly 2048 is representable, so it is not saturated.
  always_comb begin
    sat_val = acc[11:0];
    sat_err = 1'b0;
    if (!neg && (acc > 14'd2047)) begin
      sat_val = 12'h7FF;
      sat_err = 1'b1;
    end else if (neg && (acc > 14'd2048)) begin
      sat_val = 12'h800;
      sat_err = 1'b1;
    end else if (neg) begin
      sat_val = 12'd0 - acc[11:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ENTRY;
      key_ready   <= 1'b1;
      digit3      <= 4'd0;
      digit2      <= 4'd0;
      digit1      <= 4'd0;
      digit0      <= 4'd0;
      neg         <= 1'b0;
      digit_count <= 3'd0;
      acc         <= 14'd0;
      step        <= 2'd0;
      val_out     <= 12'd0;
      val_valid   <= 1'b0;
      val_err     <= 1'b0;
    end else begin
      val_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (key_valid && key_ready) begin
            case (key_code)
              4'hA: neg <= ~neg;
              4'hB: begin
                if (digit_count != 3'd0) begin
                  digit0      <= digit1;
                  digit1      <= digit2;
                  digit2      <= digit3;
                  digit3      <= 4'd0;
                  digit_count <= digit_count - 3'd1;
                end
              end
              4'hC: begin
                digit3      <= 4'd0;
                digit2      <= 4'd0;
                digit1      <= 4'd0;
                digit0      <= 4'd0;
                neg         <= 1'b0;
                digit_count <= 3'd0;
              end
              4'hE: begin
                state     <= CONV;
                acc       <= 14'd0;
                step      <= 2'd0;
                key_ready <= 1'b0;
              end
              default: begin
                if ((key_code <= 4'd9) && (digit_count < 3'd4)) begin
                  digit3      <= digit2;
                  digit2      <= digit1;
                  digit1      <= digit0;
                  digit0      <= key_code;
                  digit_count <= digit_count + 3'd1;
                end
              end
            endcase
          end
        end
        CONV: begin
          acc  <= mac_next;
          step <= step + 2'd1;
          if (step == 2'd3) state <= DONE;
        end
        DONE: begin
          val_out     <= sat_val;
          val_err     <= sat_err;
          val_valid   <= 1'b1;
          digit3      <= 4'd0;
          digit2      <= 4'd0;
          digit1      <= 4'd0;
          digit0      <= 4'd0;
          neg         <= 1'b0;
          digit_count <= 3'd0;
          key_ready   <= 1'b1;
          state       <= ENTRY;
        end
        default: begin
          state     <= ENTRY;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_entry_controller.sv
// Scoreboarded bench for bcd_entry_controller: expected conversions are queued
// when ENTER is pressed and compared whenever val_valid pulses.
module tb_bcd_entry_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic        neg;
  logic [2:0]  digit_count;
  logic [11:0] val_out;
  logic        val_valid;
  logic        val_err;

  typedef struct {
    logic [11:0] val;
    logic        err;
  } result_t;

  result_t scoreboard[$];
  int      check_count = 0;
  int      pass_count  = 0;
  logic    prev_valid  = 1'b0;

  bcd_entry_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .neg         (neg),
    .digit_count (digit_count),
    .val_out     (val_out),
    .val_valid   (val_valid),
    .val_err     (val_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Presses one key for a single cycle; returns on the negedge after acceptance.
  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic checkBuffer(input string tag, input logic [15:0] digits,
                             input logic [2:0] count, input logic sign);
    checkOutput({tag, "_digits"}, {digit3, digit2, digit1, digit0}, digits);
    checkOutput({tag, "_count"}, digit_count, count);
    checkOutput({tag, "_neg"}, neg, sign);
  endtask

  // Presses ENTER, optionally pokes a digit during CONV, and tracks key_ready.
  task automatic doEnter(input string tag, input logic [11:0] exp_val,
                         input logic exp_err, input bit poke);
    result_t r;
    r.val = exp_val;
    r.err = exp_err;
    scoreboard.push_back(r);
    applyStimulus(4'hE);
    for (int i = 1; i <= 5; i++) begin
      if (poke && i == 1) begin
        key_valid = 1'b1;
        key_code  = 4'd5;
      end
      @(negedge clk);
      key_valid = 1'b0;
      if (i < 5) checkOutput({tag, "_busy"}, key_ready, 1'b0);
    end
    checkOutput({tag, "_ready"}, key_ready, 1'b1);
    checkBuffer({tag, "_clr"}, 16'h0000, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_held_val"}, val_out, exp_val);
    checkOutput({tag, "_held_err"}, val_err, exp_err);
  endtask

  // Scoreboard consumer plus single-cycle pulse check on val_valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_valid) checkOutput("val_valid_pulse", val_valid, 1'b0);
      if (val_valid) begin
        if (scoreboard.size() == 0) begin
          checkOutput("sb_unexpected", 1, 0);
        end else begin
          result_t r;
          r = scoreboard.pop_front();
          checkOutput("sb_val_out", val_out, r.val);
          checkOutput("sb_val_err", val_err, r.err);
        end
      end
      prev_valid <= val_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    #12;
    checkOutput("rst_key_ready", key_ready, 1'b1);
    checkBuffer("rst", 16'h0000, 3'd0, 1'b0);
    checkOutput("rst_val_out", val_out, 12'd0);
    checkOutput("rst_val_valid", val_valid, 1'b0);
    checkOutput("rst_val_err", val_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3); applyStimulus(4'd4);
    checkBuffer("k1234", 16'h1234, 3'd4, 1'b0);
    doEnter("e1234", 12'h4D2, 1'b0, 1'b0);

    applyStimulus(4'hA);
    applyStimulus(4'd2); applyStimulus(4'd0); applyStimulus(4'd4); applyStimulus(4'd8);
    checkBuffer("kneg2048", 16'h2048, 3'd4, 1'b1);
    doEnter("eneg2048", 12'h800, 1'b0, 1'b0);

    applyStimulus(4'd2); applyStimulus(4'd0); applyStimulus(4'd4); applyStimulus(4'd8);
    doEnter("e2048", 12'h7FF, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(4'd9);
    doEnter("e9999", 12'h7FF, 1'b1, 1'b0);
    applyStimulus(4'hA);
    for (int i = 0; i < 4; i++) applyStimulus(4'd9);
    doEnter("eneg9999", 12'h800, 1'b1, 1'b0);

    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3); applyStimulus(4'd4);
    applyStimulus(4'd5);
    checkBuffer("full", 16'h1234, 3'd4, 1'b0);
    applyStimulus(4'hB);
    checkBuffer("bksp", 16'h0123, 3'd3, 1'b0);
    applyStimulus(4'd7);
    checkBuffer("k1237", 16'h1237, 3'd4, 1'b0);
    doEnter("e1237", 12'h4D5, 1'b0, 1'b0);

    applyStimulus(4'd3);
    applyStimulus(4'hF);
    checkBuffer("ignF", 16'h0003, 3'd1, 1'b0);
    applyStimulus(4'hA);
    applyStimulus(4'hC);
    checkBuffer("clear", 16'h0000, 3'd0, 1'b0);
    checkOutput("clear_val_kept", val_out, 12'h4D5);
    applyStimulus(4'hB);
    checkBuffer("bksp_empty", 16'h0000, 3'd0, 1'b0);
    doEnter("eempty", 12'h000, 1'b0, 1'b1);

    applyStimulus(4'hA); applyStimulus(4'hA); applyStimulus(4'hA);
    checkOutput("toggle_neg", neg, 1'b1);
    doEnter("enegzero", 12'h000, 1'b0, 1'b0);

    applyStimulus(4'd1); applyStimulus(4'd2);
    doEnter("e12", 12'h00C, 1'b0, 1'b0);

    // Reset during conversion: no result may appear.
    applyStimulus(4'd7);
    applyStimulus(4'hA);
    applyStimulus(4'hE);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_key_ready", key_ready, 1'b1);
    checkBuffer("abort", 16'h0000, 3'd0, 1'b0);
    checkOutput("abort_val_out", val_out, 12'd0);
    checkOutput("abort_val_valid", val_valid, 1'b0);
    checkOutput("abort_val_err", val_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_ready", key_ready, 1'b1);
    checkOutput("post_rst_val", val_out, 12'd0);
    applyStimulus(4'd4); applyStimulus(4'd2);
    doEnter("e42", 12'h02A, 1'b0, 1'b0);

    for (int i = 0; i < 20 && scoreboard.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drained", scoreboard.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
